// File: rtl/npu_stream_pkg.sv
// Shared types and palette for the NPU stream colourising blocks.
// Palette entries are 8-bit per channel and get MSB-aligned to the channel width.
package npu_stream_pkg;

  typedef enum logic [1:0] {
    MODE_GREY  = 2'd0,
    MODE_QUANT = 2'd1,
    MODE_ADAPT = 2'd2
  } mode_t;

  localparam int CH_MAX_W = 12;

  typedef struct packed {
    logic [CH_MAX_W-1:0] r;
    logic [CH_MAX_W-1:0] g;
    logic [CH_MAX_W-1:0] b;
  } rgb_t;

  // RRGGBB: black, blue, green, cyan, red, magenta, yellow, white
  localparam logic [23:0] PALETTE [8] = '{
    24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
    24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic mode_t to_mode(input logic [1:0] sel);
    mode_t m;
    case (sel)
      2'd1:    m = MODE_QUANT;
      2'd2:    m = MODE_ADAPT;
      default: m = MODE_GREY;
    endcase
    return m;
  endfunction

  // Result sits right-aligned in the low data_w bits of each channel field.
  function automatic logic [CH_MAX_W-1:0] align_ch(input logic [7:0] c, input int data_w);
    logic [CH_MAX_W-1:0] w;
    w = {c, 4'b0000};
    return w >> (CH_MAX_W - data_w);
  endfunction

  function automatic rgb_t palette_px(input logic [2:0] level, input int data_w);
    logic [23:0] e;
    rgb_t px;
    e = PALETTE[level];
    px.r = align_ch(e[23:16], data_w);
    px.g = align_ch(e[15:8], data_w);
    px.b = align_ch(e[7:0], data_w);
    return px;
  endfunction

endpackage

// File: rtl/pix_pos_counter.sv
// Raster x/y position tracker that advances one pixel per qualified cycle.
module pix_pos_counter #(
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1,
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          first_px,
  output logic          last_in_line,
  output logic          last_in_frame
);

  assign first_px      = (x == '0) && (y == '0);
  assign last_in_line  = (x == XW'(FRAME_W - 1));
  assign last_in_frame = last_in_line && (y == YW'(FRAME_H - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_in_line) begin
        x <= '0;
        y <= last_in_frame ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/npu_stream_colorizer.sv
// Luminance-to-RGB stream colouriser: grey, fixed palette or previous-frame-minimum
// adaptive palette, with a 2-stage pipeline and frame markers aligned to the output.
module npu_stream_colorizer
  import npu_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  parameter int LEVELS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              de_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mode_in,
  output logic              de_out,
  output logic [DATA_W-1:0] r_out,
  output logic [DATA_W-1:0] g_out,
  output logic [DATA_W-1:0] b_out,
  output logic              sof_out,
  output logic              eol_out,
  output logic              frame_done
);

  localparam int LW = $clog2(LEVELS);
  localparam int XW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  logic [XW-1:0]     pos_x;
  logic [YW-1:0]     pos_y;
  logic              first_px, last_in_line, last_in_frame;
  mode_t             active_mode, cur_mode;
  logic [DATA_W-1:0] min_prev, run_min, min_now, d_adapt, lvl_src;
  logic [LW-1:0]     level;

  logic              s1_de, s1_grey, s1_sof, s1_eol, s1_done;
  logic [DATA_W-1:0] s1_data;
  logic [2:0]        s1_level;
  rgb_t              pal;

  pix_pos_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H)
  ) u_pos (
    .clk           (clk),
    .reset         (reset),
    .advance       (de_in),
    .x             (pos_x),
    .y             (pos_y),
    .first_px      (first_px),
    .last_in_line  (last_in_line),
    .last_in_frame (last_in_frame)
  );

  logic unused_pos;
  assign unused_pos = ^{pos_x, pos_y};

  // The frame's first pixel already uses the mode being captured on its cycle.
  assign cur_mode = (de_in && first_px) ? to_mode(mode_in) : active_mode;
  assign d_adapt  = (data_in > min_prev) ? data_in - min_prev : '0;
  assign lvl_src  = (cur_mode == MODE_ADAPT) ? d_adapt : data_in;
  assign level    = lvl_src[DATA_W-1 -: LW];
  assign min_now  = (run_min < data_in) ? run_min : data_in;
  assign pal      = palette_px(s1_level, DATA_W);

  if (DATA_W < CH_MAX_W) begin : g_pal_hi
    logic unused_pal_hi;
    assign unused_pal_hi = ^{pal.r[CH_MAX_W-1:DATA_W], pal.g[CH_MAX_W-1:DATA_W],
                             pal.b[CH_MAX_W-1:DATA_W]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_mode <= MODE_GREY;
      min_prev    <= '0;
      run_min     <= '1;
      s1_de       <= 1'b0;
      s1_data     <= '0;
      s1_grey     <= 1'b0;
      s1_level    <= '0;
      s1_sof      <= 1'b0;
      s1_eol      <= 1'b0;
      s1_done     <= 1'b0;
    end else begin
      s1_de <= de_in;
      if (de_in) begin
        s1_data  <= data_in;
        s1_grey  <= (cur_mode == MODE_GREY);
        s1_level <= 3'(level);
        s1_sof   <= first_px;
        s1_eol   <= last_in_line;
        s1_done  <= last_in_frame;
        if (first_px) active_mode <= cur_mode;
        if (last_in_frame) begin
          min_prev <= min_now;
          run_min  <= '1;
        end else begin
          run_min  <= min_now;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_out     <= 1'b0;
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
      sof_out    <= 1'b0;
      eol_out    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      de_out     <= s1_de;
      sof_out    <= s1_de && s1_sof;
      eol_out    <= s1_de && s1_eol;
      frame_done <= s1_de && s1_done;
      if (s1_de) begin
        r_out <= s1_grey ? s1_data : pal.r[DATA_W-1:0];
        g_out <= s1_grey ? s1_data : pal.g[DATA_W-1:0];
        b_out <= s1_grey ? s1_data : pal.b[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_npu_stream_colorizer.sv
// Directed bench for npu_stream_colorizer on a 4x2 frame, 8-bit data, 4 levels.
module tb_npu_stream_colorizer;

  logic       clk = 1'b0;
  logic       reset;
  logic       de_in;
  logic [7:0] data_in;
  logic [1:0] mode_in;
  logic       de_out, sof_out, eol_out, frame_done;
  logic [7:0] r_out, g_out, b_out;

  int checks = 0;
  int failures = 0;

  logic [27:0] pend;
  string       pend_tag;
  logic [23:0] last_rgb;

  localparam logic [23:0] BLK = 24'h000000, BLU = 24'h0000FF,
                          GRN = 24'h00FF00, CYN = 24'h00FFFF;

  npu_stream_colorizer #(
    .DATA_W (8), .FRAME_W (4), .FRAME_H (2), .LEVELS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .de_in      (de_in),
    .data_in    (data_in),
    .mode_in    (mode_in),
    .de_out     (de_out),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .sof_out    (sof_out),
    .eol_out    (eol_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    logic [27:0] obs;
    obs = {de_out, r_out, g_out, b_out, sof_out, eol_out, frame_done};
    checks++;
    assert (obs === pend) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", pend_tag, obs, pend);
    end
  endtask

  // Drives one accepted pixel; its output is checked one call later (2-cycle latency).
  task automatic px(input logic [7:0] d, input logic [1:0] m, input logic [23:0] rgb,
                    input logic [2:0] mk, input string tag);
    de_in = 1'b1; data_in = d; mode_in = m;
    @(posedge clk); #1;
    check_out();
    pend = {1'b1, rgb, mk}; pend_tag = tag; last_rgb = rgb;
  endtask

  task automatic idle(input string tag);
    de_in = 1'b0;
    @(posedge clk); #1;
    check_out();
    pend = {1'b0, last_rgb, 3'b000}; pend_tag = tag;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; de_in = 1'b0;
    @(posedge clk); #1;
    pend = '0; pend_tag = tag;
    check_out();
    reset = 1'b0;
    last_rgb = '0; pend_tag = {tag, "_post"};
  endtask

  initial begin
    logic [7:0] v;
    logic [2:0] mk;
    reset = 1'b0; de_in = 1'b0; data_in = '0; mode_in = '0;
    pend = '0; last_rgb = '0; pend_tag = "init";
    @(posedge clk); #1;
    do_reset("reset");

    // GREY frame 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      v  = 8'(8'h10 + i);
      mk = (i == 0) ? 3'b100 : (i == 3) ? 3'b010 : (i == 7) ? 3'b011 : 3'b000;
      px(v, 2'd0, {v, v, v}, mk, $sformatf("grey_p%0d", i));
    end

    // QUANT frame
    px(8'h00, 2'd1, BLK, 3'b100, "quant_p0");
    px(8'h40, 2'd1, BLU, 3'b000, "quant_p1");
    px(8'h80, 2'd1, GRN, 3'b000, "quant_p2");
    px(8'hC0, 2'd1, CYN, 3'b010, "quant_p3");
    px(8'hFF, 2'd1, CYN, 3'b000, "quant_p4");
    px(8'h3F, 2'd1, BLK, 3'b000, "quant_p5");
    px(8'h7F, 2'd1, BLU, 3'b000, "quant_p6");
    px(8'hBF, 2'd1, GRN, 3'b011, "quant_p7");

    // ADAPT frame 1 (min_prev 0) then frame 2 back-to-back (min_prev 0x40)
    for (int i = 0; i < 8; i++) begin
      mk = (i == 0) ? 3'b100 : (i == 3) ? 3'b010 : (i == 7) ? 3'b011 : 3'b000;
      px(8'h40, 2'd2, BLU, mk, $sformatf("adapt1_p%0d", i));
    end
    px(8'h80, 2'd2, BLU, 3'b100, "adapt2_p0_collision");
    px(8'h30, 2'd2, BLK, 3'b000, "adapt2_p1_sat");
    px(8'hFF, 2'd2, GRN, 3'b000, "adapt2_p2");
    px(8'h40, 2'd2, BLK, 3'b010, "adapt2_p3");
    px(8'hC0, 2'd2, GRN, 3'b000, "adapt2_p4");
    px(8'h7F, 2'd2, BLK, 3'b000, "adapt2_p5");
    px(8'h41, 2'd2, BLK, 3'b000, "adapt2_p6");
    px(8'h20, 2'd2, BLK, 3'b011, "adapt2_p7");

    // QUANT frame with mode_in dropping to GREY from pixel 2
    px(8'h40, 2'd1, BLU, 3'b100, "mchg_p0");
    px(8'h50, 2'd1, BLU, 3'b000, "mchg_p1");
    px(8'h80, 2'd0, GRN, 3'b000, "mchg_p2");
    px(8'hC0, 2'd0, CYN, 3'b010, "mchg_p3");
    px(8'h55, 2'd0, BLU, 3'b000, "mchg_p4");
    px(8'hAA, 2'd0, GRN, 3'b000, "mchg_p5");
    px(8'h60, 2'd0, BLU, 3'b000, "mchg_p6");
    px(8'hFF, 2'd0, CYN, 3'b011, "mchg_p7");

    // GREY frame with de_in gaps inside line 0
    px(8'h21, 2'd0, 24'h212121, 3'b100, "gap_p0");
    idle("gap_hold0");
    idle("gap_hold1");
    px(8'h22, 2'd1, 24'h222222, 3'b000, "gap_p1");
    px(8'h23, 2'd1, 24'h232323, 3'b000, "gap_p2");
    idle("gap_hold2");
    px(8'h24, 2'd1, 24'h242424, 3'b010, "gap_p3_eol");
    px(8'h31, 2'd0, 24'h313131, 3'b000, "line1_p0");
    px(8'h32, 2'd0, 24'h323232, 3'b000, "line1_p1");
    px(8'h33, 2'd0, 24'h333333, 3'b000, "line1_p2");

    // Mid-frame reset: restart at (0,0) with min_prev back to 0
    do_reset("midreset");
    px(8'h50, 2'd2, BLU, 3'b100, "post_reset_sof");
    px(8'h90, 2'd2, GRN, 3'b000, "post_reset_p1");
    idle("flush0");
    idle("flush1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npu_stream_colorizer.md
Name: npu_stream_colorizer

Overview:
- Parametrised successor to the fixed 1280x720 luminance-to-RGB NPU.
- Takes a raster luminance stream qualified by de_in and tracks pixel and line position over a configurable frame.
- Maps each pixel to RGB in one of three runtime-selectable modes: grey passthrough, fixed quantise-to-palette, or adaptive (previous-frame-minimum offset) quantise-to-palette.
- Also emits start-of-frame, end-of-line and frame-done markers, aligned with the output pixels, for the downstream video sink.

Parameters:
- DATA_W, 8: luminance and per-colour-channel width in bits (4..12).
- FRAME_W, 1280: active pixels per line.
- FRAME_H, 720: active lines per frame.
- LEVELS, 4: number of quantisation levels. Power of two, 2..8.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- de_in  in  1  input pixel valid. One pixel is accepted per cycle while high.
- data_in  in  DATA_W  luminance sample.
- mode_in  in  2  mode select: 0 GREY, 1 QUANT, 2 ADAPT, 3 reserved (behaves as GREY).
- de_out  out  1  output pixel valid.
- r_out  out  DATA_W  red.
- g_out  out  DATA_W  green.
- b_out  out  DATA_W  blue.
- sof_out  out  1  high with the output of pixel (0,0).
- eol_out  out  1  high with the output of pixel x=FRAME_W-1.
- frame_done  out  1  high with the output of pixel (FRAME_W-1, FRAME_H-1).

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0.
  - x/y counters go to 0.
  - active_mode goes to GREY.
  - min_prev goes to 0.
  - run_min goes to all ones.
  - A reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- Position counters:
  - x increments on each de_in=1.
  - At x=FRAME_W-1, x wraps to 0 and y increments.
  - At (FRAME_W-1, FRAME_H-1), both wrap to 0.
  - When de_in=0, counters, run_min and the pipeline hold.
  - Gaps in de_in anywhere, including mid-line, are legal.
- Mode capture: mode_in is sampled only on the cycle de_in=1 at (0,0). The captured value (active_mode) applies to that pixel and the whole frame. mode_in changes at any other time have no effect until the next frame start.
- Pipeline: exactly 2 cycles.
  - Stage 1 registers de, data, the position flags and the level index.
  - Stage 2 registers the RGB outputs and markers.
  - de_out equals de_in delayed by 2 cycles.
  - When de_out=0, r/g/b hold their last value and all markers are 0.
- Level computation (LW = log2(LEVELS)):
  - QUANT: level = data_in[DATA_W-1 -: LW].
  - ADAPT: d = data_in - min_prev, saturated at 0. level = d[DATA_W-1 -: LW].
  - GREY: r=g=b=data_in; no palette.
- Palette lookup: r/g/b = PALETTE[level].
  - Entries are 8-bit constants, MSB-aligned to DATA_W.
  - If DATA_W > 8, pad LSBs with 0. If DATA_W < 8, truncate LSBs.
- Minimum tracking:
  - On every accepted pixel, run_min <= min(run_min, data_in).
  - On the last pixel of a frame: min_prev <= min(run_min, data_in), and run_min <= all ones.
  - ADAPT on frame N uses the minimum of frame N-1. The first frame after reset uses 0, so it equals QUANT.
- Frame-boundary collision: when the last pixel and a following (0,0) pixel arrive on consecutive cycles, the new min_prev is visible to pixel (0,0). The update is registered on the last pixel's cycle and the lookup happens on the next cycle.
- Markers: sof_out, eol_out and frame_done are single-cycle pulses coincident with de_out=1 of the respective pixel. For a frame with FRAME_H=1, eol_out and frame_done are both high on the last pixel.

Decomposition:
- Package npu_stream_pkg:
  - mode_t enum (MODE_GREY=0, MODE_QUANT=1, MODE_ADAPT=2).
  - 8-entry 24-bit PALETTE constant: black, blue, green, cyan, red, magenta, yellow, white. A LEVELS=4 design uses entries 0..3.
  - Function palette_px(level, DATA_W) returning the aligned r/g/b triple.
- Sub-module pix_pos_counter (FRAME_W, FRAME_H):
  - Inputs: clk, reset, advance.
  - Outputs: x, y, first_px, last_in_line, last_in_frame.
  - Reused by future stream blocks.

Test Plan (FRAME_W=4, FRAME_H=2, DATA_W=8, LEVELS=4 unless noted):
- Reset then GREY: stream 8 pixels 0x10..0x17 with mode_in=0.
  - de_out is high 2 cycles after de_in.
  - r=g=b=0x10..0x17.
  - sof_out on the 1st output, eol_out on the 4th and 8th, frame_done on the 8th.
- QUANT: mode_in=1, pixels 0x00, 0x40, 0x80, 0xC0 → outputs black (000000), blue (0000FF), green (00FF00), cyan (00FFFF).
- ADAPT: frame 1 is all 0x40; frame 2 has pixel 0x80 → level (0x80-0x40)>>6 = 1 → blue. Frame 2 pixel 0x30 saturates to 0 → black.
- Mode change mid-frame: mode_in switches 1→0 at pixel 2 → pixels 2..7 remain QUANT. The next frame's pixels are GREY.
- de_in gaps: de_in toggles 1,0,0,1 across a line → counters hold, 2-cycle latency preserved per pixel, eol_out still on the 4th accepted pixel. r/g/b hold during gaps.
- Reset mid-frame after 3 pixels: all outputs 0 the cycle after reset. The next accepted pixel produces sof_out, and min_prev=0.
